// File: rtl/bus_pkg.sv
// Shared definitions for the system bus arbiter.
//   BUS_AW / BUS_DW : bus address and data widths
//   state_t         : arbiter sequence IDLE -> ADDR -> ACCESS -> DONE
//   owner_t         : which pipeline stage owns the current transaction
package bus_pkg;

  localparam int BUS_AW = 23;
  localparam int BUS_DW = 16;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    ACCESS,
    DONE
  } state_t;

  typedef enum logic {
    OWN_F,
    OWN_M
  } owner_t;

endpackage

// File: rtl/bus_arb_pick.sv
// Owner selection for the bus arbiter (combinational).
//   f_req, m_req : pending requests from fetch and memory stage
//   fair_cnt     : consecutive memory grants made while fetch was waiting
//   req_any      : at least one request is pending
//   owner        : selected owner; memory wins unless fetch has waited FAIR_LIMIT grants
import bus_pkg::*;

module bus_arb_pick #(
  parameter int unsigned FAIR_LIMIT = 3
) (
  input  logic       f_req,
  input  logic       m_req,
  input  logic [3:0] fair_cnt,
  output logic       req_any,
  output owner_t     owner
);

  always_comb begin
    req_any = f_req | m_req;
    if (f_req && (!m_req || fair_cnt == 4'(FAIR_LIMIT)))
      owner = OWN_F;
    else
      owner = OWN_M;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shares the system bus between the fetch stage and the memory stage.
// Grants one transaction at a time and runs ADDR / ACCESS / DONE, with
// DONE doubling as the mandatory bus turnaround cycle.
//   _CLK, _RST               : clock, asynchronous active-low reset
//   F_REQ/F_ADDR             : fetch read request
//   F_GNT/F_DONE/F_RDATA     : fetch ownership, completion pulse, read data
//   M_REQ/M_WE/M_ADDR/M_WDATA: memory stage request
//   M_GNT/M_DONE/M_RDATA     : memory ownership, completion pulse, read data
//   BUS_*                    : bus address, data out/enable, data in, strobes, wait
//   BUSY                     : a transaction is in progress
import bus_pkg::*;

module bus_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned FAIR_LIMIT  = 3
) (
  input  logic              _CLK,
  input  logic              _RST,
  input  logic              F_REQ,
  input  logic [BUS_AW-1:0] F_ADDR,
  output logic              F_GNT,
  output logic              F_DONE,
  output logic [BUS_DW-1:0] F_RDATA,
  input  logic              M_REQ,
  input  logic              M_WE,
  input  logic [BUS_AW-1:0] M_ADDR,
  input  logic [BUS_DW-1:0] M_WDATA,
  output logic              M_GNT,
  output logic              M_DONE,
  output logic [BUS_DW-1:0] M_RDATA,
  input  logic              BUS_WAIT,
  output logic [BUS_AW-1:0] BUS_A,
  output logic [BUS_DW-1:0] BUS_D_O,
  output logic              BUS_D_OE,
  input  logic [BUS_DW-1:0] BUS_D_I,
  output logic              BUS_R,
  output logic              BUS_W,
  output logic              BUSY
);

  state_t     state;
  owner_t     owner;
  logic       lat_we;
  logic [3:0] wait_cnt;
  logic [3:0] fair_cnt;
  logic       req_any;
  owner_t     pick_owner;

  bus_arb_pick #(
    .FAIR_LIMIT(FAIR_LIMIT)
  ) u_pick (
    .f_req   (F_REQ),
    .m_req   (M_REQ),
    .fair_cnt(fair_cnt),
    .req_any (req_any),
    .owner   (pick_owner)
  );

  // BUS_A and BUS_D_O are the request latches themselves: loaded at grant and
  // held until the next grant, so the address stays stable through DONE.
  always_ff @(posedge _CLK or negedge _RST) begin
    if (!_RST) begin
      state    <= IDLE;
      owner    <= OWN_F;
      lat_we   <= 1'b0;
      wait_cnt <= '0;
      fair_cnt <= '0;
      F_GNT    <= 1'b0;
      F_DONE   <= 1'b0;
      F_RDATA  <= '0;
      M_GNT    <= 1'b0;
      M_DONE   <= 1'b0;
      M_RDATA  <= '0;
      BUS_A    <= '0;
      BUS_D_O  <= '0;
      BUS_D_OE <= 1'b0;
      BUS_R    <= 1'b0;
      BUS_W    <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      F_DONE <= 1'b0;
      M_DONE <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!F_REQ)
            fair_cnt <= '0;
          if (req_any) begin
            state <= ADDR;
            owner <= pick_owner;
            BUSY  <= 1'b1;
            if (pick_owner == OWN_F) begin
              F_GNT    <= 1'b1;
              BUS_A    <= F_ADDR;
              lat_we   <= 1'b0;
              fair_cnt <= '0;
            end else begin
              M_GNT  <= 1'b1;
              BUS_A  <= M_ADDR;
              lat_we <= M_WE;
              if (M_WE)
                BUS_D_O <= M_WDATA;
              if (F_REQ && fair_cnt != 4'(FAIR_LIMIT))
                fair_cnt <= fair_cnt + 4'd1;
            end
          end
        end
        ADDR: begin
          state    <= ACCESS;
          wait_cnt <= 4'(WAIT_CYCLES);
          BUS_R    <= !lat_we;
          BUS_W    <= lat_we;
          BUS_D_OE <= lat_we;
        end
        ACCESS: begin
          // BUS_WAIT is only looked at once the minimum wait states are spent.
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else if (!BUS_WAIT) begin
            state    <= DONE;
            BUS_R    <= 1'b0;
            BUS_W    <= 1'b0;
            BUS_D_OE <= 1'b0;
            if (!lat_we) begin
              if (owner == OWN_F)
                F_RDATA <= BUS_D_I;
              else
                M_RDATA <= BUS_D_I;
            end
            F_DONE <= (owner == OWN_F);
            M_DONE <= (owner == OWN_M);
          end
        end
        DONE: begin
          state <= IDLE;
          F_GNT <= 1'b0;
          M_GNT <= 1'b0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized
// single transactions checked against timing/ownership rules computed here.
module tb_bus_arbiter;

  localparam int WAITC = 1;
  localparam int FAIRL = 3;

  logic        clk, rst_n;
  logic        f_req, m_req, m_we, bus_wait;
  logic [22:0] f_addr, m_addr, bus_a;
  logic [15:0] m_wdata, bus_d_i, bus_d_o, f_rdata, m_rdata;
  logic        f_gnt, f_done, m_gnt, m_done, bus_d_oe, bus_r, bus_w, busy;

  int n_cmp = 0;
  int n_fail = 0;
  logic [15:0] exp_f_rdata, exp_m_rdata;

  bus_arbiter #(.WAIT_CYCLES(WAITC), .FAIR_LIMIT(FAIRL)) dut (
    ._CLK(clk), ._RST(rst_n),
    .F_REQ(f_req), .F_ADDR(f_addr), .F_GNT(f_gnt), .F_DONE(f_done), .F_RDATA(f_rdata),
    .M_REQ(m_req), .M_WE(m_we), .M_ADDR(m_addr), .M_WDATA(m_wdata),
    .M_GNT(m_gnt), .M_DONE(m_done), .M_RDATA(m_rdata),
    .BUS_WAIT(bus_wait), .BUS_A(bus_a), .BUS_D_O(bus_d_o), .BUS_D_OE(bus_d_oe),
    .BUS_D_I(bus_d_i), .BUS_R(bus_r), .BUS_W(bus_w), .BUSY(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference timing: minimum wait states, plus one cycle per BUS_WAIT cycle
  // that overlaps the point where the minimum has been spent.
  function automatic int exp_lat(input int stretch);
    return WAITC + 3 + ((stretch > WAITC) ? stretch - WAITC : 0);
  endfunction

  // Issues one request (REQ held for a single edge), plays the device side,
  // and reports what was seen on the bus. Starts and ends #1 after a posedge.
  task automatic run_txn(input bit is_f, input bit we, input logic [22:0] addr,
                         input logic [15:0] wdata, input logic [15:0] rdata, input int stretch,
                         output int lat, output int r_cyc, output int w_cyc, output int oe_cyc,
                         output int fg_cyc, output int mg_cyc, output int fd_cnt, output int md_cnt,
                         output logic [15:0] d_o_seen, output logic [22:0] a_seen,
                         output logic [15:0] rd_at_done);
    lat = 0; r_cyc = 0; w_cyc = 0; oe_cyc = 0; fg_cyc = 0; mg_cyc = 0; fd_cnt = 0; md_cnt = 0;
    d_o_seen = 'x; a_seen = 'x; rd_at_done = 'x;
    bus_d_i = rdata;
    bus_wait = 1'b0;
    if (is_f) begin
      f_req = 1'b1; f_addr = addr; m_we = 1'($urandom);
    end else begin
      m_req = 1'b1; m_addr = addr; m_we = we; m_wdata = wdata;
    end
    for (int i = 1; i <= 24; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        f_req = 1'b0; m_req = 1'b0;
        f_addr = 23'($urandom); m_addr = 23'($urandom);
        m_wdata = 16'($urandom); m_we = 1'($urandom);
      end
      if (bus_r) r_cyc++;
      if (bus_w) begin w_cyc++; d_o_seen = bus_d_o; end
      if (bus_d_oe) oe_cyc++;
      if (bus_r || bus_w) a_seen = bus_a;
      if (f_gnt) fg_cyc++;
      if (m_gnt) mg_cyc++;
      if (f_done || m_done) begin
        if (lat == 0) lat = i;
        rd_at_done = f_done ? f_rdata : m_rdata;
      end
      if (f_done) fd_cnt++;
      if (m_done) md_cnt++;
      bus_wait = (i >= 2 && i < 2 + stretch);
    end
    bus_wait = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    f_req = 0; m_req = 0; m_we = 0; bus_wait = 0;
    f_addr = '0; m_addr = '0; m_wdata = '0; bus_d_i = '0;
    #1;
    n_cmp++;
    if ({f_gnt, f_done, m_gnt, m_done, bus_d_oe, bus_r, bus_w, busy} !== 8'h00) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 00000000",
        {f_gnt, f_done, m_gnt, m_done, bus_d_oe, bus_r, bus_w, busy});
    end
    n_cmp++;
    if (bus_a !== 23'h0) begin n_fail++; $display("FAIL reset_bus_a: got %h expected 0", bus_a); end
    n_cmp++;
    if (bus_d_o !== 16'h0) begin n_fail++; $display("FAIL reset_bus_d_o: got %h expected 0", bus_d_o); end
    n_cmp++;
    if ({f_rdata, m_rdata} !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h/%h expected 0/0", f_rdata, m_rdata);
    end
    exp_f_rdata = '0; exp_m_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mem_read();
    int lat, rc, wc, oc, fg, mg, fd, md;
    logic [15:0] dseen, rdd;
    logic [22:0] aseen;
    run_txn(1'b0, 1'b0, 23'h012345, 16'h0, 16'hBEEF, 0,
            lat, rc, wc, oc, fg, mg, fd, md, dseen, aseen, rdd);
    exp_m_rdata = 16'hBEEF;
    n_cmp++;
    if (lat !== 4) begin n_fail++; $display("FAIL mread_latency: got %0d expected 4", lat); end
    n_cmp++;
    if (rc !== 2 || wc !== 0) begin n_fail++; $display("FAIL mread_strobes: got r=%0d w=%0d expected r=2 w=0", rc, wc); end
    n_cmp++;
    if (aseen !== 23'h012345) begin n_fail++; $display("FAIL mread_addr: got %h expected 012345", aseen); end
    n_cmp++;
    if (rdd !== 16'hBEEF || m_rdata !== 16'hBEEF) begin
      n_fail++; $display("FAIL mread_rdata: got %h/%h expected beef", rdd, m_rdata);
    end
    n_cmp++;
    if (fg !== 0 || md !== 1 || fd !== 0) begin
      n_fail++; $display("FAIL mread_owner: got fgnt=%0d mdone=%0d fdone=%0d expected 0/1/0", fg, md, fd);
    end
  endtask

  task automatic test_mem_write();
    int lat, rc, wc, oc, fg, mg, fd, md;
    logic [15:0] dseen, rdd;
    logic [22:0] aseen;
    run_txn(1'b0, 1'b1, 23'h7FFFFF, 16'hA5A5, 16'h1234, 0,
            lat, rc, wc, oc, fg, mg, fd, md, dseen, aseen, rdd);
    n_cmp++;
    if (wc !== 2 || oc !== 2 || rc !== 0) begin
      n_fail++; $display("FAIL mwrite_strobes: got w=%0d oe=%0d r=%0d expected 2/2/0", wc, oc, rc);
    end
    n_cmp++;
    if (dseen !== 16'hA5A5) begin n_fail++; $display("FAIL mwrite_data: got %h expected a5a5", dseen); end
    n_cmp++;
    if (aseen !== 23'h7FFFFF) begin n_fail++; $display("FAIL mwrite_addr: got %h expected 7fffff", aseen); end
    n_cmp++;
    if (m_rdata !== exp_m_rdata) begin n_fail++; $display("FAIL mwrite_rdata_kept: got %h expected %h", m_rdata, exp_m_rdata); end
    n_cmp++;
    if (lat !== 4 || md !== 1) begin n_fail++; $display("FAIL mwrite_done: got lat=%0d mdone=%0d expected 4/1", lat, md); end
  endtask

  task automatic test_bus_wait();
    int lat, rc, wc, oc, fg, mg, fd, md;
    logic [15:0] dseen, rdd;
    logic [22:0] aseen;
    run_txn(1'b1, 1'b0, 23'h2AAAAA, 16'h0, 16'hC0DE, 3,
            lat, rc, wc, oc, fg, mg, fd, md, dseen, aseen, rdd);
    exp_f_rdata = 16'hC0DE;
    n_cmp++;
    if (lat !== 6) begin n_fail++; $display("FAIL wait_latency: got %0d expected 6", lat); end
    n_cmp++;
    if (rc !== 4) begin n_fail++; $display("FAIL wait_access_len: got %0d expected 4", rc); end
    n_cmp++;
    if (rdd !== 16'hC0DE || f_rdata !== 16'hC0DE) begin
      n_fail++; $display("FAIL wait_rdata: got %h/%h expected c0de", rdd, f_rdata);
    end
    n_cmp++;
    if (mg !== 0 || fd !== 1) begin n_fail++; $display("FAIL wait_owner: got mgnt=%0d fdone=%0d expected 0/1", mg, fd); end
  endtask

  task automatic test_req_drop();
    int lat, rc, wc, oc, fg, mg, fd, md;
    logic [15:0] dseen, rdd;
    logic [22:0] aseen;
    run_txn(1'b1, 1'b0, 23'h000001, 16'h0, 16'h0F0F, 0,
            lat, rc, wc, oc, fg, mg, fd, md, dseen, aseen, rdd);
    exp_f_rdata = 16'h0F0F;
    n_cmp++;
    if (fd !== 1 || md !== 0) begin n_fail++; $display("FAIL drop_done: got fdone=%0d mdone=%0d expected 1/0", fd, md); end
    n_cmp++;
    if (fg !== exp_lat(0)) begin n_fail++; $display("FAIL drop_single_grant: got %0d gnt cycles expected %0d", fg, exp_lat(0)); end
    n_cmp++;
    if (aseen !== 23'h000001) begin n_fail++; $display("FAIL drop_addr_held: got %h expected 000001", aseen); end
  endtask

  task automatic test_fairness();
    int grants = 0;
    int gap = 0;
    bit prev = 1'b0;
    bit cur, want_f;
    f_req = 1'b1; m_req = 1'b1; m_we = 1'b0; bus_wait = 1'b0;
    f_addr = 23'($urandom); m_addr = 23'($urandom); bus_d_i = 16'h5A3C;
    for (int c = 0; c < 200 && grants < 8; c++) begin
      @(posedge clk); #1;
      cur = f_gnt | m_gnt;
      n_cmp++;
      if (f_gnt && m_gnt) begin n_fail++; $display("FAIL fair_exclusive: got both grants expected one"); end
      if (cur && !prev) begin
        want_f = (grants % (FAIRL + 1)) == FAIRL;
        n_cmp++;
        if (f_gnt !== want_f) begin
          n_fail++; $display("FAIL fair_order: grant %0d got fetch=%b expected fetch=%b", grants, f_gnt, want_f);
        end
        if (grants > 0) begin
          n_cmp++;
          if (gap !== 1) begin n_fail++; $display("FAIL fair_gap: grant %0d got %0d idle cycles expected 1", grants, gap); end
        end
        grants++;
        gap = 0;
      end
      if (!busy) gap++;
      prev = cur;
    end
    n_cmp++;
    if (grants !== 8) begin n_fail++; $display("FAIL fair_timeout: got %0d grants expected 8", grants); end
    f_req = 1'b0; m_req = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    exp_f_rdata = 16'h5A3C; exp_m_rdata = 16'h5A3C;
  endtask

  task automatic test_reset_mid_access();
    int lat, rc, wc, oc, fg, mg, fd, md;
    int done_seen = 0;
    logic [15:0] dseen, rdd;
    logic [22:0] aseen;
    m_req = 1'b1; m_we = 1'b1; m_addr = 23'h155555; m_wdata = 16'h3C3C;
    @(posedge clk); #1;   // ADDR
    m_req = 1'b0;
    @(posedge clk); #1;   // first ACCESS cycle
    @(posedge clk); #1;   // second ACCESS cycle
    n_cmp++;
    if (bus_w !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got bus_w=%b expected 1", bus_w); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus_w, bus_d_oe, m_gnt, busy} !== 4'b0000) begin
      n_fail++; $display("FAIL rstmid_async: got w/oe/gnt/busy=%b expected 0000", {bus_w, bus_d_oe, m_gnt, busy});
    end
    exp_f_rdata = '0; exp_m_rdata = '0;
    repeat (3) begin
      @(posedge clk); #1;
      if (m_done) done_seen++;
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    if (m_done) done_seen++;
    n_cmp++;
    if (done_seen !== 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_after: got dones=%0d busy=%b expected 0/0", done_seen, busy);
    end
    run_txn(1'b0, 1'b0, 23'h00ABCD, 16'h0, 16'h6789, 0,
            lat, rc, wc, oc, fg, mg, fd, md, dseen, aseen, rdd);
    exp_m_rdata = 16'h6789;
    n_cmp++;
    if (lat !== exp_lat(0) || m_rdata !== 16'h6789 || md !== 1) begin
      n_fail++; $display("FAIL rstmid_fresh: got lat=%0d rdata=%h mdone=%0d expected %0d/6789/1", lat, m_rdata, md, exp_lat(0));
    end
  endtask

  task automatic test_random();
    int lat, rc, wc, oc, fg, mg, fd, md, st, el;
    logic [15:0] dseen, rdd, wd, rd;
    logic [22:0] aseen, ad;
    bit is_f, we;
    for (int n = 0; n < 16; n++) begin
      is_f = 1'($urandom);
      we   = is_f ? 1'b0 : 1'($urandom);
      ad   = 23'($urandom);
      wd   = 16'($urandom);
      rd   = 16'($urandom);
      st   = int'($urandom_range(0, 4));
      run_txn(is_f, we, ad, wd, rd, st, lat, rc, wc, oc, fg, mg, fd, md, dseen, aseen, rdd);
      el = exp_lat(st);
      if (!we) begin
        if (is_f) exp_f_rdata = rd; else exp_m_rdata = rd;
      end
      n_cmp++;
      if (lat !== el) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", n, lat, el); end
      n_cmp++;
      if (rc !== (we ? 0 : el - 2) || wc !== (we ? el - 2 : 0) || oc !== wc) begin
        n_fail++; $display("FAIL rnd_strobes[%0d]: got r=%0d w=%0d oe=%0d expected strobe len %0d we=%b", n, rc, wc, oc, el - 2, we);
      end
      n_cmp++;
      if (aseen !== ad) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h expected %h", n, aseen, ad); end
      n_cmp++;
      if (fg !== (is_f ? el : 0) || mg !== (is_f ? 0 : el) || fd !== int'(is_f) || md !== int'(!is_f)) begin
        n_fail++; $display("FAIL rnd_owner[%0d]: got fg=%0d mg=%0d fd=%0d md=%0d expected owner fetch=%b len %0d", n, fg, mg, fd, md, is_f, el);
      end
      n_cmp++;
      if (f_rdata !== exp_f_rdata || m_rdata !== exp_m_rdata) begin
        n_fail++; $display("FAIL rnd_rdata[%0d]: got %h/%h expected %h/%h", n, f_rdata, m_rdata, exp_f_rdata, exp_m_rdata);
      end
      if (we) begin
        n_cmp++;
        if (dseen !== wd) begin n_fail++; $display("FAIL rnd_wdata[%0d]: got %h expected %h", n, dseen, wd); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mem_read();
    test_mem_write();
    test_bus_wait();
    test_req_drop();
    test_fairness();
    test_reset_mid_access();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
